// File: rtl/tristate_bus_pkg.sv
// Shared definitions for the tristate bus arbiter: FSM state encoding
// plus small constant-friendly helpers used for sizing and counting.
package tristate_bus_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   // Ceiling log2, never smaller than 1 so a 1-bit field always exists
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

   // Number of set bits in a vector of up to 16 drivers
   function automatic int popcount(input logic [15:0] v);
      int          c;
      logic [15:0] t;
      c = 0;
      t = v;
      for (int i = 0; i < 16; i++) begin
         c = c + int'(t[0]);
         t = t >> 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_arbiter.sv
// Rotating-priority picker: returns a one-hot vector selecting the first
// requester found when scanning upward from rr_ptr, wrapping at N_DRV.
module rr_arbiter
   import tristate_bus_pkg::*;
#(
   parameter int N_DRV = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_DRV-1:0] req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N_DRV-1:0] grant_next
);

   logic [PTR_W-1:0] idx;
   logic             found;
   int               pos;

   // Scan all N_DRV positions starting at rr_ptr and keep only the first hit
   always_comb begin
      grant_next = '0;
      found      = 1'b0;
      idx        = '0;
      pos        = 0;
      for (int i = 0; i < N_DRV; i++) begin
         pos = int'(rr_ptr) + i;
         if (pos >= N_DRV) begin
            pos = pos - N_DRV;
         end
         idx = PTR_W'(pos);
         if (!found && req[idx]) begin
            grant_next[idx] = 1'b1;
            found           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Shared tristate bus: N_DRV registered drivers onto one resolved wire.
// Enables come from a round-robin arbiter with burst hold, or straight
// from the registered requests in raw mode. Contention is counted.
module tristate_bus_arbiter
   import tristate_bus_pkg::*;
#(
   parameter int N_DRV     = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4,
   parameter int ARBITRATE = 1,
   parameter int CNT_W     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_DRV-1:0]       req,
   input  logic [N_DRV*WIDTH-1:0] data,
   output wire  [WIDTH-1:0]       bus,
   output logic [N_DRV-1:0]       grant,
   output logic                   bus_valid,
   output logic                   contention,
   output logic [CNT_W-1:0]       contention_cnt
);

   localparam int PTR_W  = clog2(N_DRV);
   localparam int BEAT_W = clog2(MAX_BURST + 1);

   state_t                      state_q, state_d;
   logic [PTR_W-1:0]            owner_q, owner_d;
   logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]            owner_inc, arb_ptr, arb_idx;
   logic [BEAT_W-1:0]           beat_q, beat_d;
   logic [N_DRV-1:0]            owner_mask, arb_grant, fsm_grant, grant_d;
   logic [N_DRV-1:0][WIDTH-1:0] data_q;
   logic                        contention_d;

   // Next owner position after the current one, and where the picker starts
   always_comb begin
      owner_inc  = (owner_q == PTR_W'(N_DRV - 1)) ? '0 : owner_q + 1'b1;
      owner_mask = N_DRV'(1) << owner_q;
      arb_ptr    = (state_q == ST_OWN) ? owner_inc : rr_ptr_q;
   end

   generate
      if (ARBITRATE != 0) begin : g_arb
         rr_arbiter #(
            .N_DRV (N_DRV),
            .PTR_W (PTR_W)
         ) u_rr (
            .req        (req),
            .rr_ptr     (arb_ptr),
            .grant_next (arb_grant)
         );
      end else begin : g_raw
         assign arb_grant = '0;
      end
   endgenerate

   // Convert the picker's one-hot result into an owner index
   always_comb begin
      arb_idx = '0;
      for (int i = 0; i < N_DRV; i++) begin
         if (arb_grant[i]) begin
            arb_idx = PTR_W'(i);
         end
      end
   end

   // Ownership FSM: hold for up to MAX_BURST beats, hand over on release
   // or burst expiry without an idle bubble when others are waiting
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      beat_d    = beat_q;
      rr_ptr_d  = rr_ptr_q;
      fsm_grant = '0;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               fsm_grant = arb_grant;
               owner_d   = arb_idx;
               beat_d    = BEAT_W'(1);
               state_d   = ST_OWN;
            end else begin
               beat_d = '0;
            end
         end
         ST_OWN: begin
            if (req[owner_q]) begin
               if (beat_q < BEAT_W'(MAX_BURST)) begin
                  fsm_grant = owner_mask;
                  beat_d    = beat_q + 1'b1;
               end else if ((req & ~owner_mask) != '0) begin
                  fsm_grant = arb_grant;
                  owner_d   = arb_idx;
                  rr_ptr_d  = owner_inc;
                  beat_d    = BEAT_W'(1);
               end else begin
                  fsm_grant = owner_mask;
                  beat_d    = BEAT_W'(1);
               end
            end else if (|req) begin
               fsm_grant = arb_grant;
               owner_d   = arb_idx;
               beat_d    = BEAT_W'(1);
            end else begin
               state_d = ST_IDLE;
               beat_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            beat_d  = '0;
         end
      endcase
   end

   // Select the enable source and flag multi-driver cycles
   always_comb begin
      grant_d      = (ARBITRATE != 0) ? fsm_grant : req;
      contention_d = popcount(16'(grant_d)) > 1;
   end

   // Register enables, driver data, status flags and the saturating counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         owner_q        <= '0;
         rr_ptr_q       <= '0;
         beat_q         <= '0;
         grant          <= '0;
         data_q         <= '0;
         bus_valid      <= 1'b0;
         contention     <= 1'b0;
         contention_cnt <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_q     <= beat_d;
         grant      <= grant_d;
         data_q     <= data;
         bus_valid  <= |grant_d;
         contention <= contention_d;
         if (contention_d && (contention_cnt != '1)) begin
            contention_cnt <= contention_cnt + 1'b1;
         end
      end
   end

   // One tristate driver per source; the wire resolves overlaps
   generate
      for (genvar i = 0; i < N_DRV; i++) begin : g_drv
         assign bus = grant[i] ? data_q[i] : {WIDTH{1'bz}};
      end
   endgenerate

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: four instances (burst 4, burst 1, raw,
// raw with a 2-bit counter) share one stimulus stream and are compared
// against an integer ownership/contention model each cycle.
module tb_tristate_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] data;

   wire  [7:0]  bus_arb, bus_mb1, bus_raw, bus_sat;
   logic [3:0]  grant_arb, grant_mb1, grant_raw, grant_sat;
   logic        valid_arb, valid_mb1, valid_raw, valid_sat;
   logic        cont_arb, cont_mb1, cont_raw, cont_sat;
   logic [7:0]  cnt_arb, cnt_mb1, cnt_raw;
   logic [1:0]  cnt_sat;

   int tests    = 0;
   int failures = 0;

   // Reference model state
   int         m_owner[2];
   int         m_beat[2];
   int         m_ptr[2];
   int         m_cnt[4];
   logic [3:0] exp_grant[4];
   logic [7:0] m_dq[4];
   int         max_burst[2] = '{4, 1};
   int         cnt_cap[4]   = '{255, 255, 255, 3};

   always #5 clk = ~clk;

   tristate_bus_arbiter #(.N_DRV(4), .WIDTH(8), .MAX_BURST(4), .ARBITRATE(1), .CNT_W(8)) dut_arb (
      .clk(clk), .rst_n(rst_n), .req(req), .data(data), .bus(bus_arb), .grant(grant_arb),
      .bus_valid(valid_arb), .contention(cont_arb), .contention_cnt(cnt_arb));

   tristate_bus_arbiter #(.N_DRV(4), .WIDTH(8), .MAX_BURST(1), .ARBITRATE(1), .CNT_W(8)) dut_mb1 (
      .clk(clk), .rst_n(rst_n), .req(req), .data(data), .bus(bus_mb1), .grant(grant_mb1),
      .bus_valid(valid_mb1), .contention(cont_mb1), .contention_cnt(cnt_mb1));

   tristate_bus_arbiter #(.N_DRV(4), .WIDTH(8), .MAX_BURST(4), .ARBITRATE(0), .CNT_W(8)) dut_raw (
      .clk(clk), .rst_n(rst_n), .req(req), .data(data), .bus(bus_raw), .grant(grant_raw),
      .bus_valid(valid_raw), .contention(cont_raw), .contention_cnt(cnt_raw));

   tristate_bus_arbiter #(.N_DRV(4), .WIDTH(8), .MAX_BURST(4), .ARBITRATE(0), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .req(req), .data(data), .bus(bus_sat), .grant(grant_sat),
      .bus_valid(valid_sat), .contention(cont_sat), .contention_cnt(cnt_sat));

   // First requester at or after 'start', wrapping; -1 when nobody asks
   function automatic int scanFrom(input logic [3:0] rq, input int start);
      int idx;
      for (int i = 0; i < 4; i++) begin
         idx = (start + i) % 4;
         if (((rq >> idx) & 4'b0001) != 4'b0000) begin
            return idx;
         end
      end
      return -1;
   endfunction

   task automatic check(input string name, input logic [7:0] obs, input logic [7:0] expv);
      tests++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
      end
   endtask

   // Advance the model by one clock edge given the inputs seen at that edge
   task automatic modelStep(input logic r, input logic [3:0] rq, input logic [31:0] d);
      logic ownReq;
      logic others;
      int   nxt;
      for (int k = 0; k < 2; k++) begin
         if (!r) begin
            m_owner[k] = -1;
            m_beat[k]  = 0;
            m_ptr[k]   = 0;
         end else if (m_owner[k] < 0) begin
            if (rq != 4'b0000) begin
               m_owner[k] = scanFrom(rq, m_ptr[k]);
               m_beat[k]  = 1;
            end
         end else begin
            ownReq = ((rq >> m_owner[k]) & 4'b0001) != 4'b0000;
            others = (rq & ~(4'b0001 << m_owner[k])) != 4'b0000;
            nxt    = (m_owner[k] + 1) % 4;
            if (ownReq) begin
               if (m_beat[k] < max_burst[k]) begin
                  m_beat[k] = m_beat[k] + 1;
               end else if (others) begin
                  m_owner[k] = scanFrom(rq, nxt);
                  m_ptr[k]   = nxt;
                  m_beat[k]  = 1;
               end else begin
                  m_beat[k] = 1;
               end
            end else if (rq != 4'b0000) begin
               m_owner[k] = scanFrom(rq, nxt);
               m_beat[k]  = 1;
            end else begin
               m_owner[k] = -1;
               m_beat[k]  = 0;
            end
         end
         exp_grant[k] = (m_owner[k] < 0) ? 4'b0000 : (4'b0001 << m_owner[k]);
      end
      exp_grant[2] = r ? rq : 4'b0000;
      exp_grant[3] = r ? rq : 4'b0000;
      for (int k = 0; k < 4; k++) begin
         if (!r) begin
            m_cnt[k] = 0;
         end else if (($countones(exp_grant[k]) > 1) && (m_cnt[k] < cnt_cap[k])) begin
            m_cnt[k] = m_cnt[k] + 1;
         end
      end
      for (int j = 0; j < 4; j++) begin
         m_dq[j] = r ? d[j*8 +: 8] : 8'h00;
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [31:0] d);
      rst_n = r;
      req   = rq;
      data  = d;
      modelStep(r, rq, d);
      @(posedge clk);
      #2;
   endtask

   // Compare one instance with the model; bus bits where granted drivers
   // disagree, or where nothing drives, are not compared
   task automatic checkDut(input string tag, input int k, input logic [3:0] g, input logic v,
                           input logic c, input logic [7:0] n, input logic [7:0] b);
      logic [7:0] val;
      logic [7:0] mask;
      logic       any;
      val  = 8'h00;
      mask = 8'h00;
      any  = 1'b0;
      check({tag, " grant"}, 8'(g), 8'(exp_grant[k]));
      check({tag, " bus_valid"}, 8'(v), 8'(exp_grant[k] != 4'b0000));
      check({tag, " contention"}, 8'(c), 8'($countones(exp_grant[k]) > 1));
      check({tag, " cnt"}, n, 8'(m_cnt[k]));
      for (int j = 0; j < 4; j++) begin
         if (((exp_grant[k] >> j) & 4'b0001) != 4'b0000) begin
            if (!any) begin
               val  = m_dq[j];
               mask = 8'hFF;
               any  = 1'b1;
            end else begin
               mask = mask & ~(val ^ m_dq[j]);
            end
         end
      end
      if (any) begin
         check({tag, " bus"}, b & mask, val & mask);
      end
   endtask

   task automatic checkOutput();
      checkDut("arb", 0, grant_arb, valid_arb, cont_arb, cnt_arb, bus_arb);
      checkDut("mb1", 1, grant_mb1, valid_mb1, cont_mb1, cnt_mb1, bus_mb1);
      checkDut("raw", 2, grant_raw, valid_raw, cont_raw, cnt_raw, bus_raw);
      checkDut("sat", 3, grant_sat, valid_sat, cont_sat, 8'(cnt_sat), bus_sat);
   endtask

   initial begin
      logic [3:0]  rq;
      logic        r;
      logic [7:0]  expBus;
      rst_n = 1'b0;
      req   = 4'b0000;
      data  = 32'h0;
      rq    = 4'b0000;

      // Reset held for two cycles with no requests
      applyStimulus(1'b0, 4'b0000, 32'h0);
      checkOutput();
      applyStimulus(1'b0, 4'b0000, 32'h0);
      checkOutput();
      check("reset grant", 8'(grant_arb), 8'h00);
      check("reset bus_valid", 8'(valid_arb), 8'h00);
      check("reset cnt", cnt_raw, 8'h00);

      // Single driver 2 carrying A5
      applyStimulus(1'b1, 4'b0100, 32'h00A5_0000);
      checkOutput();
      check("single grant", 8'(grant_arb), 8'h04);
      check("single bus", bus_arb, 8'hA5);
      check("single bus_valid", 8'(valid_arb), 8'h01);
      applyStimulus(1'b1, 4'b0000, 32'h0);
      checkOutput();

      // Burst rotation between drivers 0 and 1
      for (int c = 0; c < 9; c++) begin
         applyStimulus(1'b1, 4'b0011, 32'h4433_2211);
         checkOutput();
         expBus = (c < 4) ? 8'h11 : ((c < 8) ? 8'h22 : 8'h11);
         check($sformatf("burst bus c%0d", c), bus_arb, expBus);
         expBus = ((c % 2) == 0) ? 8'h11 : 8'h22;
         check($sformatf("mb1 rotate c%0d", c), bus_mb1, expBus);
      end

      // Early release: owner 0 at beat 2 drops its request
      applyStimulus(1'b1, 4'b0011, 32'h4433_2211);
      checkOutput();
      check("release pre bus", bus_arb, 8'h11);
      applyStimulus(1'b1, 4'b0010, 32'h4433_2211);
      checkOutput();
      check("release grant", 8'(grant_arb), 8'h02);
      check("release bus_valid", 8'(valid_arb), 8'h01);

      // Raw-mode contention between F0 and FF
      applyStimulus(1'b0, 4'b0000, 32'h0);
      checkOutput();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 4'b0011, 32'h0000_FFF0);
         checkOutput();
      end
      check("raw contention", 8'(cont_raw), 8'h01);
      check("raw cnt3", cnt_raw, 8'h03);
      check("raw bus upper", 8'(bus_raw[7:4]), 8'h0F);
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b1, 4'b0011, 32'h0000_FFF0);
         checkOutput();
      end
      check("sat cnt", 8'(cnt_sat), 8'h03);
      check("raw cnt5", cnt_raw, 8'h05);

      // Reset in the middle of a burst
      applyStimulus(1'b0, 4'b0011, 32'h0000_FFF0);
      checkOutput();
      check("midrst grant", 8'(grant_arb), 8'h00);
      check("midrst bus_valid", 8'(valid_arb), 8'h00);
      check("midrst sat cnt", 8'(cnt_sat), 8'h00);

      // Randomised traffic with occasional resets and sticky request patterns
      for (int c = 0; c < 600; c++) begin
         r = ($urandom_range(0, 59) != 0);
         if ($urandom_range(0, 3) == 0) begin
            rq = 4'($urandom);
         end
         applyStimulus(r, rq, $urandom);
         checkOutput();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
